// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target engine.
package spi_target_pkg;

   // Fewest synchroniser flops that still give a safe metastability margin.
   localparam int unsigned SYNC_STAGES_MIN = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

endpackage

// File: rtl/spi_target_sync.sv
// N-stage synchroniser for one asynchronous pin, plus a history flop for edge strobes.
//   clk, rst_n : system clock, async active-low reset
//   din        : asynchronous pin
//   level      : synchronised value (last synchroniser flop)
//   rise_c     : one-cycle strobe on a synchronised 0->1 transition
//   fall_c     : one-cycle strobe on a synchronised 1->0 transition
module spi_target_sync #(
   parameter int unsigned STAGES    = 2,
   parameter bit          RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise_c,
   output logic fall_c
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;
   logic [STAGES:0]   fill_q;

   // Synchroniser chain, history flop and a fill marker that walks in after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
         hist_q <= RESET_VAL;
         fill_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         hist_q <= sync_q[STAGES-1];
         fill_q <= {fill_q[STAGES-1:0], 1'b1};
      end
   end

   assign level = sync_q[STAGES-1];

   // Strobes stay masked until both level and history hold real pin samples, so a
   // pin sitting away from its idle value at reset release is not seen as an edge.
   assign rise_c = fill_q[STAGES] &  level & ~hist_q;
   assign fall_c = fill_q[STAGES] & ~level &  hist_q;

endmodule

// File: rtl/spi_target.sv
// SPI target engine: oversamples sclk/ss/mosi in the io_clock domain, deserialises
// MOSI into words and serialises MISO from a valid/ready tx stream.
//   io_clock, io_reset_n         : system clock, async active-low reset
//   io_spi_sclk/ss/mosi          : SPI pins from the controller (asynchronous)
//   io_spi_miso, io_spi_miso_oe  : MISO data and its output enable
//   io_rx_valid, io_rx_payload   : received-word pulse and held word
//   io_tx_valid/ready/payload    : tx word stream (ready pulses when a word is taken)
//   io_tx_underrun               : pulse when FILL_WORD was loaded instead of tx data
//   io_frame_abort               : pulse when ss deasserts mid-word
//   io_busy                      : high while selected
module spi_target
   import spi_target_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH  = 8,
   parameter bit                    CPOL        = 1'b0,
   parameter int unsigned           SYNC_STAGES = 2,
   parameter logic [DATA_WIDTH-1:0] FILL_WORD   = '1
) (
   input  logic                  io_clock,
   input  logic                  io_reset_n,
   input  logic                  io_spi_sclk,
   input  logic                  io_spi_ss,
   input  logic                  io_spi_mosi,
   output logic                  io_spi_miso,
   output logic                  io_spi_miso_oe,
   output logic                  io_rx_valid,
   output logic [DATA_WIDTH-1:0] io_rx_payload,
   input  logic                  io_tx_valid,
   output logic                  io_tx_ready,
   input  logic [DATA_WIDTH-1:0] io_tx_payload,
   output logic                  io_tx_underrun,
   output logic                  io_frame_abort,
   output logic                  io_busy
);

   localparam int unsigned STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
   localparam int unsigned CNT_W  = $clog2(DATA_WIDTH + 1);

   logic sclk_level, sclk_rise_c, sclk_fall_c;
   logic ss_level, ss_rise_c, ss_fall_c;
   logic mosi_level, mosi_rise_c, mosi_fall_c;
   logic unused_c;

   spi_target_sync #(.STAGES(STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
      .clk(io_clock), .rst_n(io_reset_n), .din(io_spi_sclk),
      .level(sclk_level), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c));

   spi_target_sync #(.STAGES(STAGES), .RESET_VAL(1'b1)) u_sync_ss (
      .clk(io_clock), .rst_n(io_reset_n), .din(io_spi_ss),
      .level(ss_level), .rise_c(ss_rise_c), .fall_c(ss_fall_c));

   spi_target_sync #(.STAGES(STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(io_clock), .rst_n(io_reset_n), .din(io_spi_mosi),
      .level(mosi_level), .rise_c(mosi_rise_c), .fall_c(mosi_fall_c));

   assign unused_c = ^{sclk_level, ss_level, mosi_rise_c, mosi_fall_c};

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] rx_payload_q, rx_payload_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  reload_q, reload_d;
   logic                  skip_q, skip_d;
   logic                  miso_q, miso_d;
   logic                  miso_oe_q, miso_oe_d;
   logic                  busy_q, busy_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  tx_ready_q, tx_ready_d;
   logic                  tx_underrun_q, tx_underrun_d;
   logic                  frame_abort_q, frame_abort_d;
   logic                  do_load;
   logic [DATA_WIDTH-1:0] load_word_c;

   assign load_word_c = io_tx_valid ? io_tx_payload : FILL_WORD;

   // State and datapath registers.
   always_ff @(posedge io_clock or negedge io_reset_n) begin
      if (!io_reset_n) begin
         state_q       <= ST_IDLE;
         tx_shift_q    <= '0;
         rx_shift_q    <= '0;
         rx_payload_q  <= '0;
         bit_cnt_q     <= '0;
         reload_q      <= 1'b0;
         skip_q        <= 1'b0;
         miso_q        <= 1'b1;
         miso_oe_q     <= 1'b0;
         busy_q        <= 1'b0;
         rx_valid_q    <= 1'b0;
         tx_ready_q    <= 1'b0;
         tx_underrun_q <= 1'b0;
         frame_abort_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         tx_shift_q    <= tx_shift_d;
         rx_shift_q    <= rx_shift_d;
         rx_payload_q  <= rx_payload_d;
         bit_cnt_q     <= bit_cnt_d;
         reload_q      <= reload_d;
         skip_q        <= skip_d;
         miso_q        <= miso_d;
         miso_oe_q     <= miso_oe_d;
         busy_q        <= busy_d;
         rx_valid_q    <= rx_valid_d;
         tx_ready_q    <= tx_ready_d;
         tx_underrun_q <= tx_underrun_d;
         frame_abort_q <= frame_abort_d;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d       = state_q;
      tx_shift_d    = tx_shift_q;
      rx_shift_d    = rx_shift_q;
      rx_payload_d  = rx_payload_q;
      bit_cnt_d     = bit_cnt_q;
      reload_d      = reload_q;
      skip_d        = skip_q;
      miso_d        = miso_q;
      miso_oe_d     = miso_oe_q;
      busy_d        = busy_q;
      rx_valid_d    = 1'b0;
      tx_ready_d    = 1'b0;
      tx_underrun_d = 1'b0;
      frame_abort_d = 1'b0;
      do_load       = 1'b0;

      // Deselect wins over any sclk edge seen in the same cycle.
      if (ss_rise_c && (state_q != ST_IDLE)) begin
         state_d       = ST_IDLE;
         miso_oe_d     = 1'b0;
         miso_d        = 1'b1;
         busy_d        = 1'b0;
         frame_abort_d = (bit_cnt_q != '0);
         bit_cnt_d     = '0;
         reload_d      = 1'b0;
         skip_d        = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ss_fall_c) state_d = ST_LOAD;
            end
            ST_LOAD: begin
               do_load   = 1'b1;
               bit_cnt_d = '0;
               busy_d    = 1'b1;
               miso_oe_d = 1'b1;
               reload_d  = 1'b0;
               // Mode 3 opens with a falling edge whose MSB is already on miso.
               skip_d    = CPOL;
               state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
               if (sclk_rise_c) begin
                  rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_level};
                  if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                     rx_payload_d = rx_shift_d;
                     rx_valid_d   = 1'b1;
                     bit_cnt_d    = '0;
                     reload_d     = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
               if (sclk_fall_c) begin
                  if (skip_q) begin
                     skip_d = 1'b0;
                  end else if (reload_q) begin
                     do_load  = 1'b1;
                     reload_d = 1'b0;
                  end else begin
                     tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                     miso_d     = tx_shift_q[DATA_WIDTH-2];
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase

         // Pop the tx stream, or fall back to FILL_WORD when nothing is offered.
         if (do_load) begin
            tx_shift_d    = load_word_c;
            miso_d        = load_word_c[DATA_WIDTH-1];
            tx_ready_d    = io_tx_valid;
            tx_underrun_d = ~io_tx_valid;
         end
      end
   end

   assign io_spi_miso    = miso_q;
   assign io_spi_miso_oe = miso_oe_q;
   assign io_rx_valid    = rx_valid_q;
   assign io_rx_payload  = rx_payload_q;
   assign io_tx_ready    = tx_ready_q;
   assign io_tx_underrun = tx_underrun_q;
   assign io_frame_abort = frame_abort_q;
   assign io_busy        = busy_q;

endmodule
